// File: rtl/scan_timing_if.sv
// Pixel-timing output bundle: coordinates, visible-area flag, syncs and ticks.
interface scan_timing_if #(
  parameter int unsigned pA = 12
);
  logic [pA-1:0] pix_x;
  logic [pA-1:0] pix_y;
  logic          pix_v;
  logic          hsync_n;
  logic          vsync_n;
  logic          pix_tick;
  logic          frame_tick;

  modport master (
    output pix_x, pix_y, pix_v, hsync_n, vsync_n, pix_tick, frame_tick
  );

  modport slave (
    input  pix_x, pix_y, pix_v, hsync_n, vsync_n, pix_tick, frame_tick
  );
endinterface

// File: rtl/scan_timing.sv
// 640x480@60 style scan generator: clk prescaler, 800x525 raster counters,
// visible-area and sync decode.
module scan_timing #(
  parameter int unsigned pA  = 12,
  parameter int unsigned DIV = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  scan_timing_if.master vga
);
  localparam int unsigned   PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'd799;
  localparam logic [9:0]    V_LAST   = 10'd524;
  localparam logic [9:0]    H_VIS    = 10'd640;
  localparam logic [9:0]    V_VIS    = 10'd480;
  localparam logic [9:0]    HS_FIRST = 10'd656;
  localparam logic [9:0]    HS_LAST  = 10'd751;
  localparam logic [9:0]    VS_FIRST = 10'd490;
  localparam logic [9:0]    VS_LAST  = 10'd491;

  logic [PW-1:0] r_pre;
  logic [9:0]    r_h;
  logic [9:0]    r_v;
  logic          r_run;

  logic w_tick;
  logic w_h_end;
  logic w_v_end;

  // Gating with run keeps the DIV=1 tick low while held in reset.
  assign w_tick  = r_run && (r_pre == PRE_LAST);
  // >= rather than == so a corrupted counter wraps on its next advance.
  assign w_h_end = (r_h >= H_LAST);
  assign w_v_end = (r_v >= V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_h   <= '0;
      r_v   <= '0;
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
      r_pre <= (r_pre >= PRE_LAST) ? '0 : r_pre + 1'b1;
      if (w_tick) begin
        r_h <= w_h_end ? '0 : r_h + 1'b1;
        if (w_h_end) begin
          r_v <= w_v_end ? '0 : r_v + 1'b1;
        end
      end
    end
  end

  always_comb begin
    vga.pix_x      = pA'(r_h);
    vga.pix_y      = pA'(r_v);
    vga.pix_v      = r_run && (r_h < H_VIS) && (r_v < V_VIS);
    vga.hsync_n    = !(r_run && (r_h >= HS_FIRST) && (r_h <= HS_LAST));
    vga.vsync_n    = !(r_run && (r_v >= VS_FIRST) && (r_v <= VS_LAST));
    vga.pix_tick   = w_tick;
    vga.frame_tick = w_tick && (r_h == H_LAST) && (r_v == V_LAST);
  end
endmodule

// File: tb/tb_scan_timing.sv
// Directed bench for scan_timing at DIV=4, 2 and 1 with a per-clk decode scoreboard.
module tb_scan_timing;
  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;
  int k;
  logic sb_en  = 1'b0;
  logic sb_rng = 1'b1;

  scan_timing_if #(.pA(12)) if4 ();
  scan_timing_if #(.pA(12)) if2 ();
  scan_timing_if #(.pA(12)) if1 ();

  scan_timing #(.pA(12), .DIV(4)) u4 (.clk(clk), .rst_n(rst_n), .vga(if4));
  scan_timing #(.pA(12), .DIV(2)) u2 (.clk(clk), .rst_n(rst_n), .vga(if2));
  scan_timing #(.pA(12), .DIV(1)) u1 (.clk(clk), .rst_n(rst_n), .vga(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] dec(input logic run, input logic [11:0] x, input logic [11:0] y);
    logic pv, hs, vs;
    pv = run && (x < 12'd640) && (y < 12'd480);
    hs = !(run && (x >= 12'd656) && (x <= 12'd751));
    vs = !(run && (y >= 12'd490) && (y <= 12'd491));
    return {pv, hs, vs};
  endfunction

  // Edges since reset release; the tick period follows from it alone.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  task automatic sb_one(input string tag, input int div, input logic [11:0] x, input logic [11:0] y,
                        input logic pv, input logic hs, input logic vs, input logic tk);
    check({tag, "_decode"}, {29'd0, pv, hs, vs}, {29'd0, dec(k != 0, x, y)});
    check({tag, "_tick"}, {31'd0, tk}, {31'd0, (k != 0) && ((k % div) == div - 1)});
    if (sb_rng) check({tag, "_range"}, {31'd0, (x <= 12'd799) && (y <= 12'd524)}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (sb_en) begin
      sb_one("sb4", 4, if4.pix_x, if4.pix_y, if4.pix_v, if4.hsync_n, if4.vsync_n, if4.pix_tick);
      sb_one("sb2", 2, if2.pix_x, if2.pix_y, if2.pix_v, if2.hsync_n, if2.vsync_n, if2.pix_tick);
      sb_one("sb1", 1, if1.pix_x, if1.pix_y, if1.pix_v, if1.hsync_n, if1.vsync_n, if1.pix_tick);
    end
  end

  task automatic check_reset4(input string tag);
    check({tag, "_x"},  {20'd0, if4.pix_x}, 32'd0);
    check({tag, "_y"},  {20'd0, if4.pix_y}, 32'd0);
    check({tag, "_pv"}, {31'd0, if4.pix_v}, 32'd0);
    check({tag, "_hs"}, {31'd0, if4.hsync_n}, 32'd1);
    check({tag, "_vs"}, {31'd0, if4.vsync_n}, 32'd1);
    check({tag, "_pt"}, {31'd0, if4.pix_tick}, 32'd0);
    check({tag, "_ft"}, {31'd0, if4.frame_tick}, 32'd0);
    check({tag, "_pt1"}, {31'd0, if1.pix_tick}, 32'd0);
  endtask

  initial begin
    int pv_fall_x, hs_cnt, hs_start, prev_x, vs_cnt, vs_start, ft_cnt, ft_x, ft_dly;
    logic done;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset4("rst");

    // Release between edges; edge 1 is the next posedge.
    rst_n = 1'b1;
    sb_en = 1'b1;
    @(negedge clk);
    check("e1_pv4", {31'd0, if4.pix_v}, 32'd1);
    check("e1_pt4", {31'd0, if4.pix_tick}, 32'd0);
    check("e1_x4",  {20'd0, if4.pix_x}, 32'd0);
    check("e1_pt1", {31'd0, if1.pix_tick}, 32'd1);
    check("e1_x1",  {20'd0, if1.pix_x}, 32'd0);
    check("e1_pt2", {31'd0, if2.pix_tick}, 32'd1);
    @(negedge clk);
    check("e2_pt4", {31'd0, if4.pix_tick}, 32'd0);
    check("e2_x1",  {20'd0, if1.pix_x}, 32'd1);
    check("e2_x2",  {20'd0, if2.pix_x}, 32'd1);
    @(negedge clk);
    check("e3_pt4", {31'd0, if4.pix_tick}, 32'd1);
    check("e3_x4",  {20'd0, if4.pix_x}, 32'd0);
    @(negedge clk);
    check("e4_x4",  {20'd0, if4.pix_x}, 32'd1);
    check("e4_pt4", {31'd0, if4.pix_tick}, 32'd0);

    // One full line at DIV=4.
    pv_fall_x = -1; hs_cnt = 0; hs_start = -1; prev_x = 1; done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (if4.pix_y == 12'd1) begin
        done = 1'b1;
        break;
      end
      if (!if4.pix_v && pv_fall_x < 0) pv_fall_x = int'(if4.pix_x);
      if (!if4.hsync_n) begin
        if (hs_cnt == 0) hs_start = int'(if4.pix_x);
        hs_cnt++;
      end
      prev_x = int'(if4.pix_x);
    end
    check("line_done", {31'd0, done}, 32'd1);
    check("pv_fall_x", pv_fall_x, 32'd640);
    check("hs_cycles", hs_cnt, 32'd384);
    check("hs_start_x", hs_start, 32'd656);
    check("wrap_prev_x", prev_x, 32'd799);
    check("wrap_x", {20'd0, if4.pix_x}, 32'd0);
    check("wrap_pv", {31'd0, if4.pix_v}, 32'd1);

    // Vertical sync at DIV=1, jumping to the start of line 489.
    @(negedge clk);
    force u1.r_v = 10'd489;
    force u1.r_h = 10'd0;
    #1;
    release u1.r_v;
    release u1.r_h;
    vs_cnt = 0; vs_start = -1; done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (if1.pix_y == 12'd493) begin
        done = 1'b1;
        break;
      end
      if (!if1.vsync_n) begin
        if (vs_cnt == 0) vs_start = int'(if1.pix_y);
        vs_cnt++;
      end
    end
    check("vs_done", {31'd0, done}, 32'd1);
    check("vs_cycles", vs_cnt, 32'd1600);
    check("vs_start_y", vs_start, 32'd490);

    // Frame wrap at DIV=1 from (790,524).
    force u1.r_v = 10'd524;
    force u1.r_h = 10'd790;
    #1;
    release u1.r_v;
    release u1.r_h;
    ft_cnt = 0; ft_x = -1; ft_dly = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (if1.frame_tick) begin
        ft_cnt++;
        ft_x = int'(if1.pix_x);
        ft_dly = i;
      end
      if (i == 10) begin
        check("fw_x", {20'd0, if1.pix_x}, 32'd0);
        check("fw_y", {20'd0, if1.pix_y}, 32'd0);
      end
    end
    check("ft_count", ft_cnt, 32'd1);
    check("ft_x", ft_x, 32'd799);
    check("ft_delay", ft_dly, 32'd9);

    // Corrupted counters at DIV=2 wrap on their next advance.
    sb_rng = 1'b0;
    force u2.r_h = 10'd1000;
    #1;
    release u2.r_h;
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if2.pix_x != 12'd1000) begin
        done = 1'b1;
        break;
      end
    end
    check("seu_h_done", {31'd0, done}, 32'd1);
    check("seu_h_x", {20'd0, if2.pix_x}, 32'd0);
    force u2.r_v = 10'd700;
    force u2.r_h = 10'd799;
    #1;
    release u2.r_v;
    release u2.r_h;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if2.pix_x != 12'd799) break;
    end
    check("seu_v_x", {20'd0, if2.pix_x}, 32'd0);
    check("seu_v_y", {20'd0, if2.pix_y}, 32'd0);
    @(negedge clk);
    sb_rng = 1'b1;

    // Asynchronous reset mid-line at (700,300), DIV=4.
    force u4.r_v = 10'd300;
    force u4.r_h = 10'd700;
    #1;
    release u4.r_v;
    release u4.r_h;
    @(negedge clk);
    check("pre_hs", {31'd0, if4.hsync_n}, 32'd0);
    check("pre_y",  {20'd0, if4.pix_y}, 32'd300);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset4("arst");
    repeat (3) @(negedge clk);
    check_reset4("arst_hold");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rel_x", {20'd0, if4.pix_x}, 32'd1);
    check("rel_y", {20'd0, if4.pix_y}, 32'd0);
    check("rel_pv", {31'd0, if4.pix_v}, 32'd1);

    repeat (20) @(negedge clk);
    sb_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/scan_timing.md
SCAN_TIMING -- requirements
Module: scan_timing

Interface
REQ-001 Parameter: pA, 12, width of the pix_x/pix_y coordinate buses.
REQ-002 Parameter: DIV, 4, number of clk cycles per pixel; legal range 1..16.
REQ-003 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: pix_x  output  pA  current horizontal count, 0..799.
REQ-006 Port: pix_y  output  pA  current vertical count, 0..524.
REQ-007 Port: pix_v  output  1  high when the current pixel is in the 640x480 visible area.
REQ-008 Port: hsync_n  output  1  horizontal sync, active-low.
REQ-009 Port: vsync_n  output  1  vertical sync, active-low.
REQ-010 Port: pix_tick  output  1  one-clk pulse on the last clk cycle of each pixel period.
REQ-011 Port: frame_tick  output  1  one-clk pulse coincident with the pix_tick that wraps (799,524) to (0,0).

Function
REQ-012 The prescaler counts 0..DIV-1 on every clk and wraps to 0. pix_tick SHALL be high exactly when the prescaler equals DIV-1. With DIV=1, pix_tick SHALL be constantly high after reset.
REQ-013 The horizontal counter h SHALL advance by 1 only on clk edges where pix_tick is high, and SHALL wrap 799 -> 0.
REQ-014 The vertical counter v SHALL advance by 1 only on a pix_tick edge where h=799, and SHALL wrap 524 -> 0 in the same edge that h wraps.
REQ-015 pix_x SHALL equal h and pix_y SHALL equal v with zero added latency. Upper bits beyond those needed SHALL be zero.
REQ-016 pix_v SHALL be high iff run=1, h<640 and v<480.
REQ-017 hsync_n SHALL be low iff run=1 and 656<=h<=751 (front porch 16, sync 96, back porch 48).
REQ-018 vsync_n SHALL be low iff run=1 and 490<=v<=491 (front porch 10, sync 2, back porch 33).
REQ-019 run is an internal flag: 0 in reset, set to 1 on the first clk edge after rst_n deasserts, and held at 1 thereafter.
REQ-020 frame_tick SHALL be high iff pix_tick=1, h=799 and v=524. It SHALL pulse once per 800*525*DIV clk cycles.
REQ-021 A line is 800 pixels and a frame is 525 lines. No other totals are reachable.
REQ-022 All comparisons are unsigned.
REQ-023 The counters SHALL never leave their legal ranges. Any out-of-range value (for example after an SEU) SHALL wrap to 0 on the next advance.

Reset
REQ-024 While rst_n=0, regardless of clk, the block SHALL hold: prescaler=0, h=0, v=0, run=0, pix_x=0, pix_y=0, pix_v=0, hsync_n=1, vsync_n=1, pix_tick=0, frame_tick=0.
REQ-025 Reset asserted mid-frame SHALL clear all state immediately (asynchronously), with no completion of the current line.
REQ-026 On the first clk edge after release: run=1 and the prescaler becomes 1 (DIV>1), so pix_v=1 at (0,0). The first pix_tick occurs DIV-1 edges after release.

Verification
REQ-027 Reset release, DIV=4: pix_v 0 -> 1 on the first edge. pix_tick first high 3 edges after release. pix_x = 1 after edge 4.
REQ-028 Free-run one line, DIV=4: pix_v falls when pix_x=640. hsync_n low for exactly 96*4=384 clk cycles, starting at pix_x=656. pix_x wraps 799 -> 0 and pix_y increments by 1 on the same edge.
REQ-029 Free-run one frame, DIV=1: vsync_n low for exactly 2*800=1600 clk cycles starting at pix_y=490. frame_tick pulses once after 420000 cycles, then again after another 420000.
REQ-030 Assert rst_n=0 at pix_x=700, pix_y=300 between clk edges: all outputs reach their REQ-024 values without a clk edge. After release, counting restarts from (0,0).
REQ-031 Scoreboard (DIV in {1,2,4}): on every clk, pix_v, hsync_n and vsync_n match the decode of pix_x/pix_y. pix_x stays <=799 and pix_y stays <=524 throughout 3 full frames.
